// File: rtl/rvfi_seq_pkg.sv
// Shared definitions for the RVFI retire sequencer: packed record layout, FSM states
// and small helpers used by the buffer and the top level.
`ifndef RVFI_ILEN
`define RVFI_ILEN 32
`endif
`ifndef RVFI_XLEN
`define RVFI_XLEN 32
`endif

package rvfi_seq_pkg;

    localparam int ILEN = `RVFI_ILEN;
    localparam int XLEN = `RVFI_XLEN;
    localparam int REG_W = 5;

    // Record layout, LSB first: order, insn, trap, halt, intr, rs1, rs2, rd, pc, mem_addr.
    localparam int ORDER_LSB    = 0;
    localparam int ORDER_W      = 64;
    localparam int INSN_LSB     = ORDER_LSB + ORDER_W;
    localparam int TRAP_BIT     = INSN_LSB + ILEN;
    localparam int HALT_BIT     = TRAP_BIT + 1;
    localparam int INTR_BIT     = HALT_BIT + 1;
    localparam int RS1_LSB      = INTR_BIT + 1;
    localparam int RS2_LSB      = RS1_LSB + REG_W;
    localparam int RD_LSB       = RS2_LSB + REG_W;
    localparam int PC_LSB       = RD_LSB + REG_W;
    localparam int MEM_ADDR_LSB = PC_LSB + XLEN;
    localparam int PKT_W        = MEM_ADDR_LSB + XLEN;

    localparam int MAX_NRET = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] popcount_nret(input logic [MAX_NRET-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_NRET; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [ORDER_W-1:0] pkt_order(input logic [PKT_W-1:0] p);
        return p[ORDER_LSB +: ORDER_W];
    endfunction

endpackage

// File: rtl/rvfi_seq_fifo.sv
// Circular buffer with up to NRET compacted writes and one read per cycle.
// The caller guarantees room for every lane set in wr_mask and never reads when empty.
module rvfi_seq_fifo
    import rvfi_seq_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NRET-1:0]       wr_mask,
    input  logic [NRET*PKT_W-1:0] wr_data,
    input  logic                  rd_en,
    output logic [PKT_W-1:0]      rd_data,
    output logic [CNT_W-1:0]      count
);

    logic [PKT_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    slot [NRET];
    logic [MAX_NRET-1:0] mask_ext;
    logic [3:0]          n_wr;

    always_comb begin
        mask_ext = '0;
        mask_ext[NRET-1:0] = wr_mask;
        n_wr = popcount_nret(mask_ext);
    end

    // Each written lane lands after all lower-index written lanes of the same group.
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            slot[i] = wr_ptr;
            for (int j = 0; j < i; j++) begin
                slot[i] = slot[i] + PTR_W'(wr_mask[j]);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET; i++) begin
            if (wr_mask[i]) begin
                mem[slot[i]] <= wr_data[i*PKT_W +: PKT_W];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_wr);
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(n_wr) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Serializes an NRET-wide RVFI retire bus into one in-order stream, checks order contiguity
// and stops intake once a halting instruction has been accepted.
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NRET-1:0]       in_valid,
    input  logic [NRET*PKT_W-1:0] in_pkt,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PKT_W-1:0]      out_pkt,
    output logic                  order_err,
    output logic                  drop_err,
    output logic                  done,
    output state_t                state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NRET_C  = CNT_W'(NRET);

    // Handshakes: a group transfers on an edge where in_ready=1 and any in_valid bit is set;
    // the head transfers where out_valid=1 and out_ready=1. Readiness never looks at valid.
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count;
    logic [PKT_W-1:0]   head;
    logic [NRET-1:0]    wr_mask;
    logic               halt_hit;
    logic               lane_drop;
    logic               accept;
    logic               pop;
    logic [ORDER_W-1:0] expect_order;
    logic               expect_vld;

    assign in_ready  = resetn && (state_q == RUN) && ((DEPTH_C - count) >= NRET_C);
    assign accept    = in_ready && (|in_valid);
    assign out_valid = (count != '0) && (state_q != DONE);
    assign pop       = out_valid && out_ready;
    assign out_pkt   = out_valid ? head : '0;
    assign state     = state_q;

    // Lanes above the first halting lane are discarded rather than stored.
    always_comb begin
        wr_mask   = '0;
        halt_hit  = 1'b0;
        lane_drop = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                if (halt_hit) begin
                    lane_drop = 1'b1;
                end else begin
                    wr_mask[i] = accept;
                    halt_hit   = in_pkt[i*PKT_W + HALT_BIT];
                end
            end
        end
    end

    rvfi_seq_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .wr_mask (wr_mask),
        .wr_data (in_pkt),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            RUN: begin
                if (accept && halt_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RUN;
            expect_vld   <= 1'b0;
            expect_order <= '0;
            order_err    <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                if (expect_vld && (pkt_order(head) != expect_order)) begin
                    order_err <= 1'b1;
                end
                expect_order <= pkt_order(head) + 64'd1;
                expect_vld   <= 1'b1;
            end
            if (accept && lane_drop) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule
